// File: rtl/dmem_resp.sv
// dmem_resp: word-addressed data-memory responder. Serves one load/store request
// at a time and returns a single-cycle response after a fixed latency.
//
// state | meaning
// IDLE  | req_ready high, waiting for a load/store request
// BUSY  | latency down-counter running
// RESP  | resp_valid high for exactly one cycle
module dmem_resp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              resp_valid,
  output logic              resp_is_write,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic              accept, req_err, do_wr, do_rd, enter_resp;
  logic              pend_err_q, pend_err_d;
  logic              pend_wr_q, pend_wr_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic              err_q, resp_wr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [15:0]       rd_count_q, wr_count_q;
  logic              unused_addr;

  assign idx         = addr[ADDR_W+1:2];
  assign unused_addr = ^addr[31:ADDR_W+2];

  assign accept  = !rst && req_valid && (state_q == IDLE) && (mem_read || mem_write);
  assign req_err = (mem_read && mem_write) || (addr[1:0] != 2'b00);
  assign do_wr   = accept && mem_write && !req_err;
  assign do_rd   = accept && mem_read && !req_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = LAT_M1;
          state_d = (LAT_M1 == 4'd0) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pending response is bypassed so LATENCY=1 can enter RESP on the accept edge.
  always_comb begin
    pend_err_d  = pend_err_q;
    pend_wr_d   = pend_wr_q;
    pend_data_d = pend_data_q;
    if (accept) begin
      pend_err_d  = req_err;
      pend_wr_d   = mem_write && !mem_read;
      pend_data_d = do_rd ? mem[idx] : '0;
    end
  end

  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      pend_err_q  <= 1'b0;
      pend_wr_q   <= 1'b0;
      pend_data_q <= '0;
      err_q       <= 1'b0;
      resp_wr_q   <= 1'b0;
      rdata_q     <= '0;
      rd_count_q  <= 16'd0;
      wr_count_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_err_q  <= pend_err_d;
      pend_wr_q   <= pend_wr_d;
      pend_data_q <= pend_data_d;
      if (enter_resp) begin
        err_q     <= pend_err_d;
        resp_wr_q <= pend_wr_d;
        rdata_q   <= pend_data_d;
      end
      if (do_rd && (rd_count_q != 16'hFFFF)) rd_count_q <= rd_count_q + 16'd1;
      if (do_wr && (wr_count_q != 16'hFFFF)) wr_count_q <= wr_count_q + 16'd1;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[idx] <= wdata;
  end

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = (state_q == RESP);
  assign resp_is_write = resp_wr_q;
  assign err           = err_q;
  assign rdata         = rdata_q;
  assign rd_count      = rd_count_q;
  assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: randomized and directed checks of dmem_resp (LATENCY=2 and
// LATENCY=1 instances) against a request-level reference model.
module tb_dmem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel, req_v, mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic        req_valid0, req_valid1;

  logic        rdy0, rv0, iw0, err0, rdy1, rv1, iw1, err1;
  logic [31:0] rdata0, rdata1;
  logic [15:0] rc0, wc0, rc1, wc1;

  logic        s_ready, s_rv, s_iw, s_err;
  logic [31:0] s_rdata;
  logic [15:0] s_rc, s_wc;

  assign req_valid0 = req_v && !sel;
  assign req_valid1 = req_v && sel;
  assign s_ready = sel ? rdy1 : rdy0;
  assign s_rv    = sel ? rv1 : rv0;
  assign s_iw    = sel ? iw1 : iw0;
  assign s_err   = sel ? err1 : err0;
  assign s_rdata = sel ? rdata1 : rdata0;
  assign s_rc    = sel ? rc1 : rc0;
  assign s_wc    = sel ? wc1 : wc0;

  dmem_resp #(.DATA_W(32), .ADDR_W(8), .LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(rdy0),
    .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .wdata(wdata),
    .resp_valid(rv0), .resp_is_write(iw0), .rdata(rdata0), .err(err0),
    .rd_count(rc0), .wr_count(wc0)
  );

  dmem_resp #(.DATA_W(32), .ADDR_W(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(rdy1),
    .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .wdata(wdata),
    .resp_valid(rv1), .resp_is_write(iw1), .rdata(rdata1), .err(err1),
    .rd_count(rc1), .wr_count(wc1)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_m [2][256];
  bit          known [2][256];
  int          rdc [2];
  int          wrc [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s sel=%0d got=%0h exp=%0h t=%0t", tag, sel, got, exp, $time);
    end
  endtask

  // One request, issued at a negedge with the selected instance idle.
  task automatic do_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    int          s, lat;
    logic        e, iw;
    logic [31:0] er;
    logic [7:0]  ix;
    bit          chk_rd;
    s      = sel ? 1 : 0;
    lat    = sel ? 1 : 2;
    e      = (r && w) || (a[1:0] != 2'b00);
    iw     = (r && w) ? 1'b0 : w;
    ix     = a[9:2];
    er     = 32'h0;
    chk_rd = 1'b1;
    if (!e && w) begin
      mem_m[s][ix] = d;
      known[s][ix] = 1'b1;
      if (wrc[s] < 65535) wrc[s]++;
    end
    if (!e && r) begin
      er     = mem_m[s][ix];
      chk_rd = known[s][ix];
      if (rdc[s] < 65535) rdc[s]++;
    end
    req_v = 1'b1; mem_read = r; mem_write = w; addr = a; wdata = d;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("ready_busy", 64'(s_ready), 64'(0));
      chk("resp_valid", 64'(s_rv), 64'(k == lat));
      if (k == 1) begin
        chk("rd_count", 64'(s_rc), 64'(rdc[s]));
        chk("wr_count", 64'(s_wc), 64'(wrc[s]));
      end
      if (k == lat) begin
        chk("resp_err", 64'(s_err), 64'(e));
        chk("resp_is_write", 64'(s_iw), 64'(iw));
        if (chk_rd) chk("rdata", 64'(s_rdata), 64'(er));
      end
      mem_read  = 1'($urandom);
      mem_write = 1'($urandom);
      addr      = $urandom;
      wdata     = $urandom;
    end
    @(negedge clk);
    chk("ready_after", 64'(s_ready), 64'(1));
    chk("pulse_end", 64'(s_rv), 64'(0));
    if (chk_rd) chk("rdata_hold", 64'(s_rdata), 64'(er));
    req_v = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic idle_noop(input int n);
    for (int i = 0; i < n; i++) begin
      req_v = 1'($urandom); mem_read = 1'b0; mem_write = 1'b0; addr = $urandom;
      @(negedge clk);
      chk("noop_resp", 64'(s_rv), 64'(0));
      chk("noop_ready", 64'(s_ready), 64'(1));
    end
    req_v = 1'b0;
  endtask

  task automatic rand_op(input logic [31:0] amask);
    int          c;
    logic        r, w;
    logic [31:0] a;
    c = int'($urandom_range(0, 9));
    a = $urandom & amask;
    a[1:0] = 2'b00;
    if (c < 4) begin r = 1'b1; w = 1'b0; end
    else if (c < 8) begin r = 1'b0; w = 1'b1; end
    else if (c == 8) begin r = 1'b1; w = 1'b1; end
    else begin
      r = 1'($urandom); w = !r;
      a[1:0] = 2'($urandom_range(1, 3));
    end
    do_req(r, w, a, $urandom);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(s_ready), 64'(1));
    chk({tag, "_rv"}, 64'(s_rv), 64'(0));
    chk({tag, "_iw"}, 64'(s_iw), 64'(0));
    chk({tag, "_err"}, 64'(s_err), 64'(0));
    chk({tag, "_rdata"}, 64'(s_rdata), 64'(0));
    chk({tag, "_rc"}, 64'(s_rc), 64'(0));
    chk({tag, "_wc"}, 64'(s_wc), 64'(0));
  endtask

  initial begin
    logic [31:0] a;
    sel = 1'b0; req_v = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    addr = 32'h0; wdata = 32'h0; rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      rdc[s] = 0; wrc[s] = 0;
      for (int i = 0; i < 256; i++) known[s][i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk_reset_outputs("por0");
    sel = 1'b1; #1; chk_reset_outputs("por1"); sel = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Load, then reset in the middle of a committed store's latency.
    do_req(0, 1, 32'h20, 32'h12345678);
    do_req(1, 0, 32'h20, 32'h0);
    req_v = 1'b1; mem_write = 1'b1; addr = 32'h24; wdata = 32'h87654321;
    @(negedge clk);
    req_v = 1'b0; mem_write = 1'b0;
    chk("mid_busy_ready", 64'(s_ready), 64'(0));
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_mid");
    mem_m[0][9] = 32'h87654321; known[0][9] = 1'b1;
    rdc[0] = 0; wrc[0] = 0; rdc[1] = 0; wrc[1] = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("dropped_resp", 64'(s_rv), 64'(0));
      chk("ready_post_rst", 64'(s_ready), 64'(1));
    end

    do_req(0, 1, 32'h10, 32'hDEADBEEF);
    do_req(1, 0, 32'h10, 32'h0);
    do_req(1, 0, 32'h24, 32'h0);
    for (int i = 0; i < 4; i++) do_req(1, 0, 32'h10, 32'h0);

    do_req(1, 0, 32'h13, 32'h0);
    do_req(1, 1, 32'h10, 32'h5);
    do_req(0, 1, 32'h400, 32'hCAFEF00D);
    do_req(1, 0, 32'h000, 32'h0);
    do_req(0, 1, 32'h2, 32'h11111111);
    do_req(1, 0, 32'h000, 32'h0);
    idle_noop(5);

    for (int i = 0; i < 256; i++) begin
      a = $urandom;
      a[9:0] = {i[7:0], 2'b00};
      do_req(0, 1, a, $urandom);
    end
    for (int i = 0; i < 300; i++) begin
      rand_op(32'hFFFF_FFFF);
      idle_noop(int'($urandom_range(0, 2)));
    end

    force dut0.wr_count_q = 16'hFFFD;
    @(negedge clk);
    release dut0.wr_count_q;
    wrc[0] = 65533;
    for (int i = 0; i < 3; i++) do_req(0, 1, 32'h40, $urandom);
    @(negedge clk);
    chk("wr_sat", 64'(s_wc), 64'(16'hFFFF));

    sel = 1'b1;
    idle_noop(3);
    do_req(0, 1, 32'h44, 32'hA5A5A5A5);
    do_req(1, 0, 32'h44, 32'h0);
    do_req(1, 0, 32'h7, 32'h0);
    do_req(1, 1, 32'h44, 32'h0);
    for (int i = 0; i < 40; i++) rand_op(32'h0000_003C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
